// File: rtl/cpu_pkg.sv
// Shared types for the multi-cycle MIPS core: sequencer states, jump selection codes
// and the branch displacement helper.
package cpu_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        EXEC   = 2'b01,
        HALTED = 2'b10
    } pc_state_t;

    typedef enum logic [1:0] {
        JS_NONE = 2'b00,
        JS_ABS  = 2'b01,
        JS_PAGE = 2'b10,
        JS_REL  = 2'b11
    } jump_sel_t;

    // Word offset from the instruction becomes a signed byte displacement.
    function automatic logic [31:0] branch_disp(input logic [15:0] offset);
        return {{14{offset[15]}}, offset, 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the PC sequencer and the rest of the core (datapath and branch_control).
interface pc_sequencer_if;

    logic        stall;
    logic [1:0]  jump_addr_selection;
    logic [31:0] rs_data;
    logic [25:0] instr_index;
    logic [15:0] branch_offset;
    logic        state;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic        active;
    logic        fault;

    modport master (
        input  stall,
        input  jump_addr_selection,
        input  rs_data,
        input  instr_index,
        input  branch_offset,
        output state,
        output pc,
        output pc_plus8,
        output active,
        output fault
    );

    modport slave (
        output stall,
        output jump_addr_selection,
        output rs_data,
        output instr_index,
        output branch_offset,
        input  state,
        input  pc,
        input  pc_plus8,
        input  active,
        input  fault
    );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational jump/branch target candidates for the instruction currently in EXEC.
module pc_target_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] rs_data,
    input  logic [25:0] instr_index,
    input  logic [15:0] branch_offset,
    output logic [31:0] cand_abs,
    output logic [31:0] cand_page,
    output logic [31:0] cand_rel
);

    assign cand_abs  = rs_data;
    assign cand_page = {pc_plus4[31:28], instr_index, 2'b00};
    assign cand_rel  = pc_plus4 + branch_disp(branch_offset);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and FETCH/EXEC sequencing; applies the branch_control selection
// after the delay slot and stops on halt (target 0) or a misaligned register jump.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
)(
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.master bus
);

    pc_state_t   fsm;
    logic        state_q;
    logic [31:0] pc_q;
    logic        active_q;
    logic        fault_q;

    logic [31:0] cand_abs_q;
    logic [31:0] cand_page_q;
    logic [31:0] cand_rel_q;

    logic [31:0] pc_plus4;
    logic [31:0] cand_abs_d;
    logic [31:0] cand_page_d;
    logic [31:0] cand_rel_d;
    logic [31:0] next_pc;
    logic        misaligned;
    jump_sel_t   sel;

    assign pc_plus4 = pc_q + 32'd4;
    assign sel      = jump_sel_t'(bus.jump_addr_selection);

    pc_target_calc u_target_calc (
        .pc_plus4      (pc_plus4),
        .rs_data       (bus.rs_data),
        .instr_index   (bus.instr_index),
        .branch_offset (bus.branch_offset),
        .cand_abs      (cand_abs_d),
        .cand_page     (cand_page_d),
        .cand_rel      (cand_rel_d)
    );

    // The selection belongs to the previous instruction, so it picks among the
    // candidates latched from that instruction, not the ones being computed now.
    always_comb begin
        next_pc    = pc_plus4;
        misaligned = 1'b0;
        case (sel)
            JS_NONE: next_pc = pc_plus4;
            JS_ABS: begin
                next_pc    = cand_abs_q;
                misaligned = (cand_abs_q[1:0] != 2'b00);
            end
            JS_PAGE: next_pc = cand_page_q;
            JS_REL:  next_pc = cand_rel_q;
            default: next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm         <= FETCH;
            state_q     <= 1'b0;
            pc_q        <= RESET_VECTOR;
            active_q    <= 1'b1;
            fault_q     <= 1'b0;
            cand_abs_q  <= 32'h0;
            cand_page_q <= 32'h0;
            cand_rel_q  <= 32'h0;
        end else begin
            case (fsm)
                FETCH: begin
                    fsm     <= EXEC;
                    state_q <= 1'b1;
                end
                EXEC: begin
                    if (!bus.stall) begin
                        cand_abs_q  <= cand_abs_d;
                        cand_page_q <= cand_page_d;
                        cand_rel_q  <= cand_rel_d;
                        state_q     <= 1'b0;
                        // A misaligned register jump wins over the halt check and keeps the delay-slot pc.
                        if (misaligned) begin
                            fsm      <= HALTED;
                            fault_q  <= 1'b1;
                            active_q <= 1'b0;
                        end else if (next_pc == 32'h0) begin
                            fsm      <= HALTED;
                            active_q <= 1'b0;
                            pc_q     <= 32'h0;
                        end else begin
                            fsm  <= FETCH;
                            pc_q <= next_pc;
                        end
                    end
                end
                HALTED: begin
                    fsm     <= HALTED;
                    state_q <= 1'b0;
                end
                default: begin
                    fsm     <= HALTED;
                    state_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state    = state_q;
    assign bus.pc       = pc_q;
    assign bus.pc_plus8 = pc_q + 32'd8;
    assign bus.active   = active_q;
    assign bus.fault    = fault_q;

endmodule
